// File: rtl/cpu_types.sv
// Shared decode/issue types and default core dimensions.
// Pure declarations: no logic, no latency, no flow control.
package cpu_types;
  localparam int DEF_XLEN         = 32;
  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_MAX_INFLIGHT = 3;
  localparam int DEF_PAYLOAD_W    = 64;
  localparam int DEF_RA_W         = $clog2(DEF_NUM_REGS);
  localparam int DEF_CNT_W        = $clog2(DEF_MAX_INFLIGHT + 1);
  localparam int REG_ZERO         = 0;

  typedef logic [DEF_RA_W-1:0]  reg_addr_t;
  typedef logic [DEF_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic [DEF_PAYLOAD_W-1:0] payload;
    reg_addr_t                rd_addr;
    logic                     rd_we;
  } issue_entry_t;
endpackage

// File: rtl/decode_issue_scoreboard_skid_buffer.sv
// In-order valid/ready FIFO with flush; a push shows on out_* one cycle later.
// Caller gates push on occupancy; pop is out_valid & out_ready and is suppressed by flush.
module skid_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CW-1:0]          count,
  output logic [DEPTH-1:0]       ent_valid,
  output logic [DEPTH*WIDTH-1:0] ent_data
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign ent_data  = mem_q;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // A physical slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW:0] off;
    assign off = (PW'(i) >= rd_ptr_q) ? (PW+1)'(i) - {1'b0, rd_ptr_q}
                                      : (PW+1)'(i + DEPTH) - {1'b0, rd_ptr_q};
    assign ent_valid[i] = (32'(off) < 32'(count_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/decode_issue_scoreboard.sv
// Decode issue unit: per-register write counters gate RAW/full hazards; accepted ops reach execute next cycle.
// in_ready depends only on buffer occupancy, flush and hazards, never on out_ready in the same cycle.
module decode_issue_scoreboard
  import cpu_types::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int NUM_RS       = 2,
  parameter int NUM_WB       = 1,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int PAYLOAD_W    = DEF_PAYLOAD_W,
  localparam int RA_W        = $clog2(NUM_REGS),
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_RS*RA_W-1:0] in_rs_addr,
  input  logic [NUM_RS-1:0]      in_rs_used,
  input  logic [RA_W-1:0]        in_rd_addr,
  input  logic                   in_rd_we,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [RA_W-1:0]        out_rd_addr,
  output logic                   out_rd_we,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*RA_W-1:0] wb_addr,
  output logic                   hazard,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic                   sb_error
);
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int DW    = CNT_W + $clog2(NUM_WB + DEPTH + 1) + 1;
  localparam int unused_xlen = XLEN;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [RA_W-1:0]      rd_addr;
    logic                 rd_we;
  } entry_t;
  localparam int EW = $bits(entry_t);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic sb_error_q, sb_error_d;
  logic [NUM_REGS-1:0] eff_busy, eff_full, uflow;
  logic [DEPTH-1:0] ent_valid, ent_we;
  logic [DEPTH*EW-1:0] ent_data;
  logic [DEPTH-1:0][RA_W-1:0] ent_rd;
  logic [OCC_W-1:0] occ;
  logic raw, full, blocked, accept;
  entry_t push_ent, head_ent;
  logic unused_payload;

  assign unused_payload = ^ent_data;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    assign ent_rd[e] = ent_data[e*EW+1 +: RA_W];
    assign ent_we[e] = ent_valid[e] & ent_data[e*EW] & (ent_rd[e] != RA_W'(REG_ZERO));
  end

  // cnt_eff = cnt - wb_dec (floored at 0) drives hazards; flush kills add to the decrement.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign busy_mask[r] = |cnt_q[r];
    if (r == REG_ZERO) begin : g_x0
      assign eff_busy[r] = 1'b0;
      assign eff_full[r] = 1'b0;
      assign uflow[r]    = 1'b0;
      assign cnt_d[r]    = '0;
    end else begin : g_trk
      logic [DW-1:0] cur, wb_dec, fl_dec;
      logic [DW:0]   up, dn;
      always_comb begin
        wb_dec = '0;
        for (int w = 0; w < NUM_WB; w++)
          if (wb_valid[w] && (wb_addr[w*RA_W +: RA_W] == RA_W'(r))) wb_dec = wb_dec + DW'(1);
        fl_dec = '0;
        for (int e = 0; e < DEPTH; e++)
          if (flush && ent_we[e] && (ent_rd[e] == RA_W'(r))) fl_dec = fl_dec + DW'(1);
      end
      assign cur         = DW'(cnt_q[r]);
      assign up          = {1'b0, cur} + (DW+1)'(accept & in_rd_we & (in_rd_addr == RA_W'(r)));
      assign dn          = {1'b0, wb_dec} + {1'b0, fl_dec};
      assign eff_busy[r] = (cur > wb_dec);
      assign eff_full[r] = (cur == wb_dec + DW'(MAX_INFLIGHT));
      assign uflow[r]    = (dn > up);
      assign cnt_d[r]    = (dn > up) ? '0 : CNT_W'(up - dn);
    end
  end

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_RS; i++)
      if (in_rs_used[i] && eff_busy[in_rs_addr[i*RA_W +: RA_W]]) raw = 1'b1;
  end

  assign full       = in_rd_we & eff_full[in_rd_addr];
  assign blocked    = raw | full;
  assign hazard     = in_valid & blocked;
  assign in_ready   = (occ < OCC_W'(DEPTH)) & ~flush & ~blocked;
  assign accept     = in_valid & in_ready;
  assign sb_error_d = sb_error_q | (|uflow);
  assign sb_error   = sb_error_q;
  assign push_ent   = {in_payload, in_rd_addr, in_rd_we};

  skid_buffer #(.WIDTH(EW), .DEPTH(DEPTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept),
    .push_data (push_ent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_ent),
    .count     (occ),
    .ent_valid (ent_valid),
    .ent_data  (ent_data)
  );

  assign out_payload = head_ent.payload;
  assign out_rd_addr = head_ent.rd_addr;
  assign out_rd_we   = head_ent.rd_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sb_error_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sb_error_q <= sb_error_d;
    end
  end
endmodule
